// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding I-memory requests and loads IF/ID.
// Optional performance counters (StallCycles, RedirectCount) are enabled by defining IF_FETCH_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        PC_WriteEnable,
  input  logic        IFIDWriteEnable,
  input  logic        IFIDFlush,
  input  logic        Branch,
  input  logic [31:0] BranchDest,
  input  logic        Jump,
  input  logic [31:0] JumpDest,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] PC
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] RedirectCount
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_KILL  = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;

  state_t      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] req_addr_q;
  logic [31:0] buf_q;
  logic        buf_valid_q;
  logic        imem_req_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_addr;
  logic [31:0] redir_or_seq;
  logic        word_avail;
  logic [31:0] word;
  logic        accept;

  assign redirect     = (Jump | Branch) & PC_WriteEnable;
  // Jump has priority; the two low target bits are forced to zero.
  assign target       = (Jump ? JumpDest : BranchDest) & ~32'h3;
  assign seq_addr     = req_addr_q + 32'd4;
  assign redir_or_seq = redirect ? target : seq_addr;
  assign word_avail   = ((state_q == S_FETCH) & IMemReady) | ((state_q == S_HOLD) & buf_valid_q);
  assign word         = (state_q == S_HOLD) ? buf_q : IMemData;
  assign accept       = word_avail & IFIDWriteEnable & PC_WriteEnable & ~redirect & ~IFIDFlush;

  assign IMemReq     = imem_req_q;
  assign IMemAddr    = req_addr_q;
  assign Instruction = instr_q;
  assign PC          = pc_q;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redirect_cnt_q;
  assign StallCycles   = stall_cnt_q;
  assign RedirectCount = redirect_cnt_q;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC_ALIGNED;
      req_addr_q  <= RESET_PC_ALIGNED;
      buf_q       <= 32'h0;
      buf_valid_q <= 1'b0;
      imem_req_q  <= 1'b0;
      instr_q     <= 32'h0;
      pc_q        <= RESET_PC_ALIGNED;
`ifdef IF_FETCH_PERF_CNT_EN
      stall_cnt_q    <= 32'h0;
      redirect_cnt_q <= 32'h0;
`endif
    end else begin
      // IF/ID register: flush beats hold beats load; an idle write is a bubble.
      if (IFIDFlush) begin
        instr_q <= 32'h0;
      end else if (IFIDWriteEnable) begin
        if (accept) begin
          instr_q <= word;
          pc_q    <= req_addr_q;
        end else begin
          instr_q <= 32'h0;
        end
      end

`ifdef IF_FETCH_PERF_CNT_EN
      if (!IFIDFlush && IFIDWriteEnable && !accept && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect && redirect_cnt_q != 32'hFFFF_FFFF)
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
`endif

      case (state_q)
        S_IDLE: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
          fetch_pc_q <= redirect ? target : fetch_pc_q;
          req_addr_q <= redirect ? target : fetch_pc_q;
        end
        S_FETCH: begin
          if (redirect && !IMemReady) begin
            // Request still in flight: its response must be swallowed first.
            state_q    <= S_KILL;
            fetch_pc_q <= target;
          end else if (redirect || accept) begin
            fetch_pc_q <= redir_or_seq;
            req_addr_q <= redir_or_seq;
          end else if (IMemReady) begin
            state_q     <= S_HOLD;
            imem_req_q  <= 1'b0;
            buf_q       <= IMemData;
            buf_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect || accept) begin
            state_q     <= S_FETCH;
            imem_req_q  <= 1'b1;
            buf_valid_q <= 1'b0;
            fetch_pc_q  <= redir_or_seq;
            req_addr_q  <= redir_or_seq;
          end
        end
        S_KILL: begin
          if (redirect)
            fetch_pc_q <= target;
          if (IMemReady) begin
            state_q    <= S_FETCH;
            req_addr_q <= redirect ? target : fetch_pc_q;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios then randomized traffic against a transaction-level model.
module tb_if_fetch_stage;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        PC_WriteEnable;
  logic        IFIDWriteEnable;
  logic        IFIDFlush;
  logic        Branch;
  logic [31:0] BranchDest;
  logic        Jump;
  logic [31:0] JumpDest;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic [31:0] PC;
`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] StallCycles;
  logic [31:0] RedirectCount;
`endif

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .PC_WriteEnable(PC_WriteEnable),
    .IFIDWriteEnable(IFIDWriteEnable),
    .IFIDFlush(IFIDFlush),
    .Branch(Branch),
    .BranchDest(BranchDest),
    .Jump(Jump),
    .JumpDest(JumpDest),
    .IMemReq(IMemReq),
    .IMemAddr(IMemAddr),
    .IMemReady(IMemReady),
    .IMemData(IMemData),
    .Instruction(Instruction),
    .PC(PC)
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    .StallCycles(StallCycles),
    .RedirectCount(RedirectCount)
`endif
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;

  // Reference model: one outstanding request, an optional held word, and the IF/ID contents.
  logic [31:0] m_fetch, m_out_addr, m_word, m_word_addr, m_instr, m_pc, m_stall, m_redir;
  bit          m_idle, m_out_valid, m_out_dead, m_have_word;

  int req_age = 0;
  int wait_n = 0;
  bit rand_mem = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_instr = 0; m_pc = 0; m_fetch = 0;
    m_idle = 1; m_out_valid = 0; m_out_dead = 0; m_have_word = 0;
    m_out_addr = 0; m_word = 0; m_word_addr = 0;
    m_stall = 0; m_redir = 0;
  endtask

  task automatic m_issue(input logic [31:0] a);
    m_out_valid = 1; m_out_dead = 0; m_out_addr = a;
  endtask

  task automatic model_step();
    bit redir, rdy, avail, acc;
    logic [31:0] tgt, w, waddr;
    if (Reset) begin
      m_reset();
      return;
    end
    redir = (Jump | Branch) & PC_WriteEnable;
    tgt   = Jump ? {JumpDest[31:2], 2'b00} : {BranchDest[31:2], 2'b00};
    rdy   = IMemReady;
    avail = 0; w = 0; waddr = 0;
    if (m_have_word) begin
      avail = 1; w = m_word; waddr = m_word_addr;
    end else if (m_out_valid && !m_out_dead && rdy) begin
      avail = 1; w = IMemData; waddr = m_out_addr;
    end
    acc = avail & IFIDWriteEnable & PC_WriteEnable & !redir & !IFIDFlush;
    if (redir && m_redir != 32'hFFFF_FFFF) m_redir++;
    if (IFIDFlush) m_instr = 0;
    else if (IFIDWriteEnable) begin
      if (acc) begin
        m_instr = w; m_pc = waddr;
      end else begin
        m_instr = 0;
        if (m_stall != 32'hFFFF_FFFF) m_stall++;
      end
    end
    if (redir) m_fetch = tgt;
    else if (acc) m_fetch = waddr + 4;
    if (m_idle) begin
      m_idle = 0;
      m_issue(m_fetch);
    end else if (m_have_word) begin
      if (redir || acc) begin
        m_have_word = 0;
        m_issue(m_fetch);
      end
    end else if (m_out_valid) begin
      if (rdy) begin
        if (m_out_dead || redir || acc) m_issue(m_fetch);
        else begin
          m_have_word = 1; m_word = w; m_word_addr = waddr; m_out_valid = 0;
        end
      end else if (redir) begin
        m_out_dead = 1;
      end
    end
  endtask

  task automatic set_mem();
    bit rdy;
    if (rand_mem) rdy = (IMemReq === 1'b1) && (req_age >= 3 || $urandom_range(2) == 0);
    else          rdy = (IMemReq === 1'b1) && (req_age >= wait_n);
    IMemReady = rdy;
    IMemData  = rdy ? IMemAddr + 32'h1000 : $urandom;
  endtask

  task automatic compare();
    chk("instr", Instruction, m_instr);
    chk("pc", PC, m_pc);
    chk("imemreq", {31'b0, IMemReq}, {31'b0, m_out_valid});
    if (m_out_valid) chk("imemaddr", IMemAddr, m_out_addr);
    chk("addr_align", {30'b0, IMemAddr[1:0]}, 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
    chk("stall_cnt", StallCycles, m_stall);
    chk("redir_cnt", RedirectCount, m_redir);
`endif
  endtask

  task automatic step();
    bit pr, py;
    pr = (IMemReq === 1'b1);
    py = IMemReady;
    @(posedge Clock);
    model_step();
    if (Reset || (pr && py)) req_age = 0;
    else if (pr) req_age++;
    #1;
    compare();
    set_mem();
  endtask

  initial begin
    Reset = 1; PC_WriteEnable = 1; IFIDWriteEnable = 1; IFIDFlush = 0;
    Branch = 0; BranchDest = 0; Jump = 0; JumpDest = 0;
    IMemReady = 0; IMemData = 0;

    // Reset state and zero-wait streaming
    step();
    chk("rst_addr", IMemAddr, 32'h0);
    chk("rst_req", {31'b0, IMemReq}, 32'h0);
    Reset = 0;
    step();
    chk("first_req", {31'b0, IMemReq}, 32'h1);
    chk("first_addr", IMemAddr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("zw_instr", Instruction, 32'h1000 + 32'(4 * k));
      chk("zw_pc", PC, 32'(4 * k));
      chk("zw_addr", IMemAddr, 32'(4 * k + 4));
    end

    // Two-cycle wait memory
    wait_n = 2;
    set_mem();
    for (int k = 0; k < 9; k++) step();

    // Stall while the word at 8 arrives
    Reset = 1; wait_n = 0;
    step();
    Reset = 0;
    step(); step(); step();
    chk("pre_hold_addr", IMemAddr, 32'h8);
    PC_WriteEnable = 0; IFIDWriteEnable = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_req", {31'b0, IMemReq}, 32'h0);
      chk("hold_instr", Instruction, 32'h1004);
      chk("hold_pc", PC, 32'h4);
    end
    PC_WriteEnable = 1; IFIDWriteEnable = 1;
    step();
    chk("release_instr", Instruction, 32'h1008);
    chk("release_pc", PC, 32'h8);
    chk("release_addr", IMemAddr, 32'hC);

    // Branch while the request to 0x10 is waiting
    wait_n = 3;
    set_mem();
    for (int k = 0; k < 30; k++) begin
      if (IMemReq && IMemAddr == 32'h10) break;
      step();
    end
    chk("reach_10", IMemAddr, 32'h10);
    Branch = 1; BranchDest = 32'h43;
    step();
    Branch = 0;
    chk("kill_req", {31'b0, IMemReq}, 32'h1);
    chk("kill_addr", IMemAddr, 32'h10);
    for (int k = 0; k < 20; k++) begin
      if (IMemReq && IMemAddr == 32'h40) break;
      step();
      chk("no_stale", {31'b0, Instruction == 32'h1010}, 32'h0);
    end
    chk("redir_addr", IMemAddr, 32'h40);
    wait_n = 0;
    set_mem();
    step();
    chk("redir_instr", Instruction, 32'h1040);
    chk("redir_pc", PC, 32'h40);

    // Jump and Branch together with flush
    Jump = 1; JumpDest = 32'h200; Branch = 1; BranchDest = 32'h40; IFIDFlush = 1;
    step();
    Jump = 0; Branch = 0; IFIDFlush = 0;
    chk("jf_instr", Instruction, 32'h0);
    chk("jf_addr", IMemAddr, 32'h200);
    step();
    chk("jump_instr", Instruction, 32'h1200);
    chk("jump_pc", PC, 32'h200);

    // Reset while a response is arriving
    Reset = 1;
    step();
    chk("midrst_instr", Instruction, 32'h0);
    chk("midrst_pc", PC, 32'h0);
    Reset = 0;

    // Randomized traffic
    rand_mem = 1;
    set_mem();
    for (int k = 0; k < 3000; k++) begin
      Reset           = ($urandom_range(199) == 0);
      PC_WriteEnable  = ($urandom_range(99) < 85);
      IFIDWriteEnable = ($urandom_range(99) < 85);
      IFIDFlush       = ($urandom_range(99) < 8);
      Branch          = ($urandom_range(99) < 8);
      Jump            = ($urandom_range(99) < 5);
      BranchDest      = $urandom;
      JumpDest        = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It is the producer side of the IF/ID interface. It owns the fetch PC and issues single-outstanding requests to instruction memory. It loads the IF/ID pipeline register that the decode stage reads, and it obeys the decode stage's stall, flush and branch/jump redirect controls.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- Clock  in  1  pipeline clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- PC_WriteEnable  in  1  0 = hold fetch PC (load-use stall)
- IFIDWriteEnable  in  1  0 = hold IF/ID register contents
- IFIDFlush  in  1  1 = load NOP into IF/ID
- Branch  in  1  taken-branch redirect request
- BranchDest  in  32  branch target
- Jump  in  1  jump redirect request
- JumpDest  in  32  jump target
- IMemReq  out  1  fetch request valid
- IMemAddr  out  32  fetch address, word aligned
- IMemReady  in  1  response valid this cycle
- IMemData  in  32  instruction word, valid when IMemReady=1
- Instruction  out  32  IF/ID instruction
- PC  out  32  IF/ID address of Instruction (decode forms PC+4 itself)

## Operation
- Internal state: FetchPC (next address to fetch), ReqAddr (drives IMemAddr), Buf/BufValid (one-word hold buffer), FSM.
- States:
  - IDLE: reset state, one cycle, IMemReq=0, then FETCH with ReqAddr=FetchPC.
  - FETCH: IMemReq=1. ReqAddr stays stable until IMemReady=1.
  - HOLD: the word has arrived but IF/ID is stalled. IMemReq=0, word kept in Buf.
  - KILL: a redirect occurred during an outstanding request. IMemReq=1 with the old ReqAddr. The response is discarded on IMemReady, then the FSM returns to FETCH at FetchPC.
- Redirect is taken when (Jump|Branch)&PC_WriteEnable. Target = Jump ? JumpDest : BranchDest (Jump wins). The redirect loads FetchPC=target and drops any available or buffered word.
  - In FETCH with IMemReady=0, the FSM goes to KILL.
  - With IMemReady=1, or from HOLD, it goes to FETCH with ReqAddr=target.
  - In KILL, FetchPC is updated and the FSM stays in KILL.
- Word available means (FETCH & IMemReady) or HOLD.
- Word accepted means available & IFIDWriteEnable & PC_WriteEnable & no redirect & no IFIDFlush.
  - On accept: Instruction←word, PC←its address, FetchPC←address+4 (wraps mod 2^32), FSM→FETCH, ReqAddr←address+4.
- Word available but not accepted, with no redirect: the FSM goes to or stays in HOLD.
- IF/ID register priority:
  1. Reset: loads 0/RESET_PC.
  2. IFIDFlush: Instruction←0 (NOP), PC unchanged.
  3. IFIDWriteEnable=0: hold.
  4. Accept: load word.
  5. Otherwise: Instruction←0 (bubble), PC unchanged.
- IMemAddr[1:0] is always 0. BranchDest/JumpDest bits [1:0] are ignored.

## Timing
- Reset values: Instruction=0, PC=RESET_PC, IMemReq=0, IMemAddr=RESET_PC, FSM=IDLE, BufValid=0, FetchPC=RESET_PC. Counters are 0 when configured in.
- First request: IMemReq=1 in the 2nd cycle after Reset deasserts.
- Zero-wait memory (IMemReady same cycle as request): one instruction per cycle. A word appears on Instruction the cycle after its IMemReady.
- N wait cycles: N bubbles (Instruction=0) per fetch.
- Redirect latency:
  - Target request issues the next cycle if no request is outstanding.
  - Otherwise it issues the cycle after the killed response.
  - The first target word appears at IF/ID one cycle after its IMemReady.
- Stall release from HOLD: the buffered word loads on the first cycle with IFIDWriteEnable=PC_WriteEnable=1, with no new memory access.
- Reset asserted mid-request: state is discarded. A response arriving in that cycle is ignored.

## Configuration
- IF_FETCH_PERF_CNT_EN defined: adds outputs StallCycles[31:0] and RedirectCount[31:0].
  - StallCycles counts cycles in which IF/ID loads a bubble (rule 5).
  - RedirectCount counts taken redirects.
  - Both saturate at 32'hFFFF_FFFF and clear on Reset.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset, zero-wait memory returning addr+32'h1000 → IMemAddr 0,4,8; Instruction 32'h1000,32'h1004,32'h1008 on consecutive cycles; PC 0,4,8.
- Two-cycle wait memory → Instruction sequence word0,0,0,word1,…; IMemAddr held stable during waits.
- IFIDWriteEnable=PC_WriteEnable=0 for 3 cycles while word at 32'h8 arrives → HOLD, IMemReq=0, Instruction/PC frozen; on release PC=8 with correct word, next IMemAddr=32'hC.
- Branch=1, BranchDest=32'h40 while request to 32'h10 is waiting → KILL, 32'h10 data never reaches Instruction, next IMemAddr=32'h40, IF/ID PC=32'h40.
- Jump=1 (JumpDest=32'h200) and Branch=1 (BranchDest=32'h40) together with IFIDFlush=1 → Instruction=0 next cycle, next fetch 32'h200.
- With IF_FETCH_PERF_CNT_EN: the above sequence → RedirectCount=2, StallCycles equal to the number of bubble cycles counted by the bench.
